// File: rtl/sample_port_pkg.sv
// Shared types for the sample_port capture block: FSM state encoding and edge-select constants.
package sample_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // True when the bit moved in the direction selected by fall.
  function automatic logic edge_hit(input logic prev_bit, input logic cur_bit, input logic fall);
    logic rise_hit;
    logic fall_hit;
    rise_hit = ~prev_bit & cur_bit;
    fall_hit = prev_bit & ~cur_bit;
    return (fall == EDGE_RISE) ? rise_hit : fall_hit;
  endfunction

endpackage

// File: rtl/sample_port_sync.sv
// Per-bit synchroniser: SYNC_STAGES flops from the asynchronous pins to the sampled vector.
module sample_port_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] s_q
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign s_q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sample_port.sv
// Capture port: synchronise pins, decimate, wait for a trigger, stream capture_len samples.
// Optional pattern trigger is enabled by defining SAMPLE_PORT_PATTERN_TRIG_EN.
module sample_port
  import sample_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16,
  parameter int LEN_W       = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pins_in,
  input  logic                     arm,
  input  logic [DIV_W-1:0]         div,
  input  logic [$clog2(WIDTH)-1:0] trig_sel,
  input  logic                     trig_fall,
  input  logic [LEN_W-1:0]         capture_len,
`ifdef SAMPLE_PORT_PATTERN_TRIG_EN
  input  logic [WIDTH-1:0]         trig_mask,
  input  logic [WIDTH-1:0]         trig_value,
  input  logic                     trig_mode,
`endif
  output logic [WIDTH-1:0]         sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic                     overflow,
  output logic [1:0]               fsm_state
);

  // Handshake: a sample transfers on any clock edge where sample_valid & sample_ready are both
  // high; sample_valid never drops and sample_data never changes until that transfer happens.

  state_t           state;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [DIV_W-1:0] cnt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_next;
  logic [LEN_W-1:0] len_eff;
  logic             strobe;
  logic             arm_ok;
  logic             edge_ok;
  logic             match;
  logic             trig;
  logic             emit;
  logic             last;

  sample_port_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .pins (pins_in),
    .s_q  (s_q)
  );

  assign strobe  = (cnt == div);
  assign arm_ok  = arm && ((state == ST_IDLE) || (state == ST_DONE));
  assign len_eff = (capture_len == '0) ? LEN_W'(1) : capture_len;
  assign edge_ok = edge_hit(prev[trig_sel], s_q[trig_sel], trig_fall);

`ifdef SAMPLE_PORT_PATTERN_TRIG_EN
  assign match = trig_mode ? ((s_q & trig_mask) == (trig_value & trig_mask)) : edge_ok;
`else
  assign match = edge_ok;
`endif

  // The priming strobe only records prev, so a stale prev from a previous run cannot trigger.
  assign trig       = (state == ST_ARMED) && primed && strobe && match;
  assign emit       = trig || ((state == ST_CAPTURE) && strobe);
  assign count_next = trig ? LEN_W'(1) : count + LEN_W'(1);
  assign last       = (count_next == len_eff);

  always_ff @(posedge clk) begin
    if (rst || arm_ok) cnt <= '0;
    else if (strobe)   cnt <= '0;
    else               cnt <= cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state  <= ST_ARMED;
            count  <= '0;
            primed <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (strobe) begin
            prev   <= s_q;
            primed <= 1'b1;
            if (trig) begin
              count <= count_next;
              state <= last ? ST_DONE : ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (strobe) begin
            count <= count_next;
            if (last) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (arm_ok) overflow <= 1'b0;
      if (emit) begin
        if (sample_valid && !sample_ready) begin
          overflow <= 1'b1;
        end else begin
          sample_data  <= s_q;
          sample_valid <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);
  assign triggered = trig;
  assign fsm_state = state;

endmodule

// File: tb/tb_sample_port.sv
// Directed bench for sample_port: edge-trigger vector table plus multi-cycle corner sequences.
module tb_sample_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pins_in;
  logic        arm;
  logic [15:0] div;
  logic [2:0]  trig_sel;
  logic        trig_fall;
  logic [11:0] capture_len;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        triggered;
  logic        done;
  logic        overflow;
  logic [1:0]  fsm_state;
`ifdef SAMPLE_PORT_PATTERN_TRIG_EN
  logic [7:0]  trig_mask;
  logic [7:0]  trig_value;
  logic        trig_mode;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  sample_port dut (
    .clk          (clk),
    .rst          (rst),
    .pins_in      (pins_in),
    .arm          (arm),
    .div          (div),
    .trig_sel     (trig_sel),
    .trig_fall    (trig_fall),
    .capture_len  (capture_len),
`ifdef SAMPLE_PORT_PATTERN_TRIG_EN
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .trig_mode    (trig_mode),
`endif
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .overflow     (overflow),
    .fsm_state    (fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arm = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Driver tasks
  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic setup(input logic [15:0] d, input logic [11:0] len, input logic rdy,
                       input logic [2:0] sel, input logic fall, input logic [7:0] p);
    div          = d;
    capture_len  = len;
    sample_ready = rdy;
    trig_sel     = sel;
    trig_fall    = fall;
    pins_in      = p;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sb_accept(input logic [7:0] data);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_extra_sample actual=%0h expected=none", data);
    end else begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (data !== e) begin
        failures++;
        $display("FAIL sb_sample actual=%0h expected=%0h", data, e);
      end
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       fall;
    logic       exp_trig;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] sched [5];
    logic       seen;
    logic       got;
    logic [7:0] data;
    int         trig_cnt;
    int         n_samples;
    int         last_idx;
    int         first_idx;
    int         bad_gap;

    vecs[0] = '{8'h00, 8'h01, 3'd0, 1'b0, 1'b1, 8'h01};
    vecs[1] = '{8'h01, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'h01, 8'h00, 3'd0, 1'b1, 1'b1, 8'h00};
    vecs[3] = '{8'h00, 8'h80, 3'd7, 1'b0, 1'b1, 8'h80};
    vecs[4] = '{8'h00, 8'h7F, 3'd7, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'hFF, 8'hF7, 3'd3, 1'b1, 1'b1, 8'hF7};
    vecs[6] = '{8'h10, 8'h10, 3'd4, 1'b0, 1'b0, 8'h00};

    rst = 1'b1;
    arm = 1'b0;
    setup(16'd0, 12'd1, 1'b1, 3'd0, 1'b0, 8'h00);
`ifdef SAMPLE_PORT_PATTERN_TRIG_EN
    trig_mask  = 8'h00;
    trig_value = 8'h00;
    trig_mode  = 1'b0;
`endif
    do_reset();

    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);

    // Edge-trigger vector table, len=1 so a trigger goes straight to DONE
    for (int v = 0; v < 7; v++) begin
      do_reset();
      setup(16'd0, 12'd1, 1'b1, vecs[v].sel, vecs[v].fall, vecs[v].a);
      repeat (3) tick();
      pulse_arm();
      repeat (3) tick();
      pins_in = vecs[v].b;
      seen = 1'b0;
      got  = 1'b0;
      data = '0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (triggered) seen = 1'b1;
        if (sample_valid && !got) begin
          got  = 1'b1;
          data = sample_data;
        end
      end
      check($sformatf("vec%0d_trig", v), 32'(seen), 32'(vecs[v].exp_trig));
      if (vecs[v].exp_trig) begin
        check($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
        check($sformatf("vec%0d_done", v), 32'(done), 32'd1);
      end else begin
        check($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      end
    end

    // len=4, div=0: four consecutive samples following the changing pins, fifth not emitted
    do_reset();
    setup(16'd0, 12'd4, 1'b1, 3'd0, 1'b0, 8'h00);
    repeat (3) tick();
    pulse_arm();
    repeat (3) tick();
    sched = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    exp_q = {};
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h0F);
    trig_cnt  = 0;
    n_samples = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 5) pins_in = sched[i];
      tick();
      if (triggered) trig_cnt++;
      if (sample_valid && sample_ready) begin
        n_samples++;
        sb_accept(sample_data);
      end
    end
    check("len4_trig_pulses", 32'(trig_cnt), 32'd1);
    check("len4_samples", 32'(n_samples), 32'd4);
    check("len4_queue_empty", 32'(exp_q.size()), 32'd0);
    check("len4_done", 32'(done), 32'd1);
    check("len4_busy", 32'(busy), 32'd0);

    // div=3: one strobe every 4 clocks
    do_reset();
    setup(16'd3, 12'd30, 1'b1, 3'd0, 1'b0, 8'h00);
    repeat (6) tick();
    pulse_arm();
    repeat (12) tick();
    pins_in = 8'h01;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (triggered) seen = 1'b1;
    end
    check("div3_trigger_seen", 32'(seen), 32'd1);
    n_samples = 0;
    last_idx  = -1;
    first_idx = -1;
    bad_gap   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sample_valid) begin
        n_samples++;
        if (first_idx < 0) first_idx = i;
        if (last_idx >= 0 && (i - last_idx) != 4) bad_gap++;
        last_idx = i;
      end
    end
    check("div3_strobes_40clk", 32'(n_samples), 32'd10);
    check("div3_first_latency", 32'(first_idx), 32'd1);
    check("div3_bad_gaps", 32'(bad_gap), 32'd0);

    // ready held low: capture #1 is kept, later samples dropped
    do_reset();
    setup(16'd0, 12'd3, 1'b0, 3'd0, 1'b0, 8'h00);
    repeat (3) tick();
    pulse_arm();
    repeat (3) tick();
    sched = '{8'h01, 8'h03, 8'h07, 8'h07, 8'h07};
    for (int i = 0; i < 12; i++) begin
      if (i < 3) pins_in = sched[i];
      tick();
    end
    check("stall_valid", 32'(sample_valid), 32'd1);
    check("stall_data", 32'(sample_data), 32'h01);
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_done", 32'(done), 32'd1);
    sample_ready = 1'b1;
    tick();
    check("stall_drain_valid", 32'(sample_valid), 32'd0);
    check("stall_overflow_sticky", 32'(overflow), 32'd1);

    // arm ignored in CAPTURE; arm in DONE re-arms, clears overflow, primes before triggering
    do_reset();
    setup(16'd0, 12'd6, 1'b0, 3'd0, 1'b0, 8'h00);
    repeat (3) tick();
    pulse_arm();
    repeat (3) tick();
    pins_in = 8'h01;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (triggered) seen = 1'b1;
    end
    check("rearm_first_trigger", 32'(seen), 32'd1);
    pulse_arm();
    repeat (8) tick();
    check("arm_in_capture_done", 32'(done), 32'd1);
    check("arm_in_capture_overflow", 32'(overflow), 32'd1);
    check("arm_in_capture_data", 32'(sample_data), 32'h01);
    trig_fall = 1'b1;
    pins_in   = 8'h00;
    repeat (4) tick();
    pulse_arm();
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_overflow_cleared", 32'(overflow), 32'd0);
    check("rearm_pending_valid", 32'(sample_valid), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (triggered) seen = 1'b1;
    end
    check("rearm_prime_no_trigger", 32'(seen), 32'd0);
    pins_in = 8'h01;
    repeat (4) tick();
    pins_in = 8'h00;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (triggered) seen = 1'b1;
    end
    check("rearm_fall_trigger", 32'(seen), 32'd1);

    // reset held 3 clocks mid-capture
    do_reset();
    setup(16'd0, 12'd20, 1'b0, 3'd0, 1'b0, 8'h00);
    repeat (3) tick();
    pulse_arm();
    repeat (3) tick();
    pins_in = 8'h01;
    repeat (5) tick();
    check("midcap_busy", 32'(busy), 32'd1);
    check("midcap_overflow", 32'(overflow), 32'd1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("abort_state", 32'(fsm_state), 32'd0);
    check("abort_valid", 32'(sample_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);

`ifdef SAMPLE_PORT_PATTERN_TRIG_EN
    // pattern trigger: upper nibble must equal 0xA
    do_reset();
    setup(16'd0, 12'd1, 1'b1, 3'd0, 1'b0, 8'h00);
    trig_mask  = 8'hF0;
    trig_value = 8'hA0;
    trig_mode  = 1'b1;
    repeat (3) tick();
    pulse_arm();
    repeat (3) tick();
    pins_in = 8'hB5;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (triggered) seen = 1'b1;
    end
    check("pattern_b5_no_trigger", 32'(seen), 32'd0);
    pins_in = 8'hA5;
    seen = 1'b0;
    got  = 1'b0;
    data = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (triggered) seen = 1'b1;
      if (sample_valid && !got) begin
        got  = 1'b1;
        data = sample_data;
      end
    end
    check("pattern_a5_trigger", 32'(seen), 32'd1);
    check("pattern_a5_data", 32'(data), 32'hA5);
    trig_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
